// File: rtl/add_rr_sched_pkg.sv
// Shared constants and types for the round-robin adder scheduler and its arbiter.
package add_sched_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 8;
    localparam int DEF_ID_W = $clog2(DEF_NREQ);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/add_rr_sched_if.sv
// Requester/consumer bundle for add_rr_sched: packed operand buses in, tagged result out.
interface add_rr_sched_if
    import add_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W
) ();

    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              cfg_sat;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_sum;
    logic              rsp_carry;
    logic [ID_W-1:0]   rsp_id;

    // Driven by the requesters and the result consumer.
    modport master (
        output req_valid, req_a, req_b, cfg_sat, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id
    );

    // Implemented by the scheduler.
    modport slave (
        input  req_valid, req_a, req_b, cfg_sat, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id
    );

endinterface

// File: rtl/add_rr_sched_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
module rr_pick
    import add_sched_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    int              pos;
    logic [ID_W-1:0] p;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = 0;
        p   = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NREQ) pos = pos - NREQ;
            p = ID_W'(pos);
            if (en && !any && req[p]) begin
                any    = 1'b1;
                idx    = p;
                gnt[p] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/add_rr_sched.sv
// Time-shares one W-bit adder among NREQ requesters with round-robin grant and a
// one-entry tagged result register.
module add_rr_sched
    import add_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    add_rr_sched_if.slave bus
);

    localparam int ID_W = $clog2(NREQ);

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q;
    logic [W-1:0]    sum_q;
    logic            carry_q;
    logic [ID_W-1:0] id_q;

    logic            can_accept;
    logic [NREQ-1:0] pick_gnt;
    logic [ID_W-1:0] pick_idx;
    logic            accept;
    logic [W-1:0]    a_sel, b_sel;
    logic [W:0]      sum_full;
    logic [W-1:0]    sum_out;

    // Grants are suppressed while reset is high even though state is already EMPTY.
    assign can_accept = !rst && ((state_q == S_EMPTY) || bus.rsp_ready);

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (bus.req_valid),
        .ptr (ptr_q),
        .en  (can_accept),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (accept)
    );

    assign bus.req_ready = pick_gnt;

    assign a_sel    = bus.req_a[pick_idx*W +: W];
    assign b_sel    = bus.req_b[pick_idx*W +: W];
    assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};
    assign sum_out  = (bus.cfg_sat && sum_full[W]) ? {W{1'b1}} : sum_full[W-1:0];

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (accept) state_d = S_FULL;
            S_FULL:  begin
                if (accept)             state_d = S_FULL;
                else if (bus.rsp_ready) state_d = S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        bus.rsp_valid = (state_q == S_FULL);
    end

    // Result fields hold their last value after the consumer drains them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= '0;
        end else if (accept) begin
            sum_q   <= sum_out;
            carry_q <= sum_full[W];
            id_q    <= pick_idx;
            ptr_q   <= (pick_idx == ID_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_carry = carry_q;
    assign bus.rsp_id    = id_q;

endmodule

// File: tb/tb_add_rr_sched.sv
// Directed bench for add_rr_sched: reset, single add, fairness, saturation,
// backpressure, pointer wrap and asynchronous reset mid-operation.
module tb_add_rr_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    add_rr_sched_if #(.NREQ(4), .W(8)) bus ();

    add_rr_sched #(.NREQ(4), .W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.req_a[i*8 +: 8] = a;
        bus.req_b[i*8 +: 8] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 1'b0;
        bus.cfg_sat   = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid = 4'b1111;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.cfg_sat = 1'b0;
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready: got %b exp %b", bus.req_ready, 4'b0000); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b exp 0", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_sum !== 8'h00) begin n_err++; $display("FAIL reset_rsp_sum: got %h exp 00", bus.rsp_sum); end
        n_cmp++; if (bus.rsp_carry !== 1'b0) begin n_err++; $display("FAIL reset_rsp_carry: got %b exp 0", bus.rsp_carry); end
        n_cmp++; if (bus.rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id: got %0d exp 0", bus.rsp_id); end
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        set_op(0, 8'h12, 8'h34);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b exp 0001", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b exp 1", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_sum !== 8'h46) begin n_err++; $display("FAIL single_sum: got %h exp 46", bus.rsp_sum); end
        n_cmp++; if (bus.rsp_carry !== 1'b0) begin n_err++; $display("FAIL single_carry: got %b exp 0", bus.rsp_carry); end
        n_cmp++; if (bus.rsp_id !== 2'd0) begin n_err++; $display("FAIL single_id: got %0d exp 0", bus.rsp_id); end
        tick();
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_drain_valid: got %b exp 0", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_sum !== 8'h46) begin n_err++; $display("FAIL single_hold_sum: got %h exp 46", bus.rsp_sum); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        logic [7:0] exp_sum;
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 8'(8'h10 * i + 1), 8'(i));
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 9; k++) begin
            exp_gnt = 4'b0001 << (k % 4);
            n_cmp++; if (bus.req_ready !== exp_gnt) begin n_err++; $display("FAIL rr_grant[%0d]: got %b exp %b", k, bus.req_ready, exp_gnt); end
            if (k > 0) begin
                exp_sum = 8'(8'h11 * ((k - 1) % 4) + 1);
                n_cmp++; if (bus.rsp_id !== 2'((k - 1) % 4)) begin n_err++; $display("FAIL rr_id[%0d]: got %0d exp %0d", k, bus.rsp_id, (k - 1) % 4); end
                n_cmp++; if (bus.rsp_sum !== exp_sum) begin n_err++; $display("FAIL rr_sum[%0d]: got %h exp %h", k, bus.rsp_sum, exp_sum); end
                n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid[%0d]: got %b exp 1", k, bus.rsp_valid); end
            end
            tick();
        end
        bus.req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        set_op(0, 8'hF0, 8'h20);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        bus.cfg_sat   = 1'b0;
        tick();
        n_cmp++; if (bus.rsp_sum !== 8'h10) begin n_err++; $display("FAIL wrap_sum: got %h exp 10", bus.rsp_sum); end
        n_cmp++; if (bus.rsp_carry !== 1'b1) begin n_err++; $display("FAIL wrap_carry: got %b exp 1", bus.rsp_carry); end
        bus.cfg_sat = 1'b1;
        tick();
        n_cmp++; if (bus.rsp_sum !== 8'hFF) begin n_err++; $display("FAIL sat_sum: got %h exp FF", bus.rsp_sum); end
        n_cmp++; if (bus.rsp_carry !== 1'b1) begin n_err++; $display("FAIL sat_carry: got %b exp 1", bus.rsp_carry); end
        set_op(0, 8'h7F, 8'h80);
        tick();
        n_cmp++; if (bus.rsp_sum !== 8'hFF) begin n_err++; $display("FAIL nosat_sum: got %h exp FF", bus.rsp_sum); end
        n_cmp++; if (bus.rsp_carry !== 1'b0) begin n_err++; $display("FAIL nosat_carry: got %b exp 0", bus.rsp_carry); end
        // A cfg_sat change must not disturb a held result.
        set_op(0, 8'hF0, 8'h20);
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 1'b0;
        bus.cfg_sat   = 1'b0;
        tick();
        n_cmp++; if (bus.rsp_sum !== 8'hFF) begin n_err++; $display("FAIL sat_held_sum: got %h exp FF", bus.rsp_sum); end
        bus.rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        set_op(0, 8'h01, 8'h02);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        tick();
        set_op(2, 8'h30, 8'h05);
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready[%0d]: got %b exp 0000", c, bus.req_ready); end
            n_cmp++; if ({bus.rsp_valid, bus.rsp_sum, bus.rsp_carry, bus.rsp_id} !== {1'b1, 8'h03, 1'b0, 2'd0}) begin
                n_err++; $display("FAIL bp_hold[%0d]: got v%b s%h c%b i%0d exp v1 s03 c0 i0", c, bus.rsp_valid, bus.rsp_sum, bus.rsp_carry, bus.rsp_id);
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_release_grant: got %b exp 0100", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        n_cmp++; if ({bus.rsp_valid, bus.rsp_sum, bus.rsp_id} !== {1'b1, 8'h35, 2'd2}) begin
            n_err++; $display("FAIL bp_new_result: got v%b s%h i%0d exp v1 s35 i2", bus.rsp_valid, bus.rsp_sum, bus.rsp_id);
        end
        tick();
    endtask

    task automatic test_pointer_skip();
        do_reset();
        set_op(0, 8'h01, 8'h01);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        tick();
        set_op(3, 8'h0A, 8'h0B);
        bus.req_valid = 4'b1001;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL skip_grant3: got %b exp 1000", bus.req_ready); end
        tick();
        n_cmp++; if (bus.rsp_id !== 2'd3 || bus.rsp_sum !== 8'h15) begin n_err++; $display("FAIL skip_result3: got i%0d s%h exp i3 s15", bus.rsp_id, bus.rsp_sum); end
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL skip_grant0: got %b exp 0001", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        n_cmp++; if (bus.rsp_id !== 2'd0 || bus.rsp_sum !== 8'h02) begin n_err++; $display("FAIL skip_result0: got i%0d s%h exp i0 s02", bus.rsp_id, bus.rsp_sum); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_op(0, 8'h50, 8'h05);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 1'b0;
        n_cmp++; if (bus.rsp_sum !== 8'h55) begin n_err++; $display("FAIL mid_loaded: got %h exp 55", bus.rsp_sum); end
        #2;
        rst = 1'b1;
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        #1;
        n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== 8'h00) begin n_err++; $display("FAIL mid_async_clear: got v%b s%h exp v0 s00", bus.rsp_valid, bus.rsp_sum); end
        n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL mid_ready_in_reset: got %b exp 0000", bus.req_ready); end
        #1;
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_first_grant: got %b exp 0001", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        n_cmp++; if (bus.rsp_id !== 2'd0 || bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL mid_first_result: got i%0d v%b exp i0 v1", bus.rsp_id, bus.rsp_valid); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_saturation();
        test_backpressure();
        test_pointer_skip();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
